// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and word-wide RAM port bundle for lsu_mem_ctrl.
// slave = controller view, master = datapath/RAM side view.
interface lsu_mem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        MemWrite;
   logic [31:0] A;
   logic [31:0] WriteData;
   logic [31:0] ReadData;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ReadData,
      output req_ready, resp_valid, resp_err, resp_rdata, MemWrite, A, WriteData
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ReadData,
      input  req_ready, resp_valid, resp_err, resp_rdata, MemWrite, A, WriteData
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Byte/halfword/word load-store controller in front of a word-wide RAM (RMW for sub-word stores).
// Define LSU_ALIGN_CHECK_EN to report misaligned accesses as errors instead of masking the address.
module lsu_mem_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int unsigned MEM_BYTES = 4096
) (
   input  logic          clk,
   input  logic          rst,
   lsu_mem_ctrl_if.slave io_bus
);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

   state_e      r_state, w_state_nxt;
   logic        r_we, r_unsigned, r_err;
   logic [1:0]  r_size, r_lane;
   logic [31:0] r_wdata, r_rword, r_a;

   logic        w_hs, w_bad_size, w_out_range, w_err;
   logic [31:0] w_offset, w_addr_eff, w_merged, w_lane, w_rdata;

   assign w_hs        = io_bus.req_valid && (r_state == StIdle);
   assign w_offset    = io_bus.req_addr - BASE_ADDR;
   assign w_bad_size  = (io_bus.req_size == 2'b11);
   assign w_out_range = (io_bus.req_addr < BASE_ADDR) || (w_offset >= 32'(MEM_BYTES));

`ifdef LSU_ALIGN_CHECK_EN
   logic w_misal;
   assign w_misal = ((io_bus.req_size == 2'b01) && io_bus.req_addr[0]) ||
                    ((io_bus.req_size == 2'b10) && (io_bus.req_addr[1:0] != 2'b00));
   assign w_err   = w_bad_size || w_out_range || w_misal;
`else
   assign w_err   = w_bad_size || w_out_range;
`endif

   // Masking is harmless when misalignment is an error: such requests never reach the RAM.
   always_comb begin
      w_addr_eff = io_bus.req_addr;
      if (io_bus.req_size == 2'b01) begin
         w_addr_eff[0] = 1'b0;
      end else if (io_bus.req_size == 2'b10) begin
         w_addr_eff[1:0] = 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= StIdle;
         r_we       <= 1'b0;
         r_unsigned <= 1'b0;
         r_err      <= 1'b0;
         r_size     <= 2'b00;
         r_lane     <= 2'b00;
         r_wdata    <= '0;
         r_rword    <= '0;
         r_a        <= BASE_ADDR;
      end else begin
         r_state <= w_state_nxt;
         if (w_hs) begin
            r_we       <= io_bus.req_we;
            r_unsigned <= io_bus.req_unsigned;
            r_err      <= w_err;
            r_size     <= io_bus.req_size;
            r_lane     <= w_addr_eff[1:0];
            r_wdata    <= io_bus.req_wdata;
            if (!w_err) begin
               r_a <= {w_addr_eff[31:2], 2'b00};
            end
         end
         if (r_state == StRd) begin
            r_rword <= io_bus.ReadData;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_hs) begin
               if (w_err) begin
                  w_state_nxt = StDone;
               end else if (io_bus.req_we && (io_bus.req_size == 2'b10)) begin
                  w_state_nxt = StWr;
               end else begin
                  w_state_nxt = StRd;
               end
            end
         end
         StRd:    w_state_nxt = r_we ? StWr : StDone;
         StWr:    w_state_nxt = StDone;
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // Merge store data into the captured word; word stores bypass the captured word.
   always_comb begin
      w_merged = r_rword;
      case (r_size)
         2'b00:   w_merged[{r_lane, 3'b000} +: 8]   = r_wdata[7:0];
         2'b01:   w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
         default: w_merged = r_wdata;
      endcase
   end

   always_comb begin
      w_lane = r_rword >> {r_lane, 3'b000};
      case (r_size)
         2'b00:   w_rdata = {{24{~r_unsigned & w_lane[7]}}, w_lane[7:0]};
         2'b01:   w_rdata = {{16{~r_unsigned & w_lane[15]}}, w_lane[15:0]};
         default: w_rdata = w_lane;
      endcase
   end

   // Gating with rst keeps a reset that lands on WR/DONE from writing or responding.
   assign io_bus.req_ready  = (r_state == StIdle);
   assign io_bus.MemWrite   = (r_state == StWr) && rst;
   assign io_bus.A          = r_a;
   assign io_bus.WriteData  = (r_state == StWr) ? w_merged : '0;
   assign io_bus.resp_valid = (r_state == StDone) && rst;
   assign io_bus.resp_err   = io_bus.resp_valid && r_err;
   assign io_bus.resp_rdata = (io_bus.resp_valid && !r_err && !r_we) ? w_rdata : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl against a byte-arithmetic reference model.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
   localparam logic [31:0] Base  = 32'h0000_1000;
   localparam int          Words = 1024;

   typedef struct packed {
      logic        err;
      logic        wr;
      logic [3:0]  lat;
      logic [31:0] aw;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   lsu_mem_ctrl_if bus ();

   lsu_mem_ctrl #(.BASE_ADDR(Base), .MEM_BYTES(4096)) dut (
      .clk   (clk),
      .rst   (rst),
      .io_bus(bus)
   );

   // RAM environment
   logic [31:0] ram [Words];
   logic        poke_en = 1'b0;
   logic [9:0]  poke_idx = '0;
   logic [31:0] poke_val = '0;
   assign bus.ReadData = ram[bus.A[11:2]];
   always @(posedge clk) begin
      if (poke_en) ram[poke_idx] <= poke_val;
      else if (bus.MemWrite) ram[bus.A[11:2]] <= bus.WriteData;
   end

   logic [31:0] ref_mem [Words];
   int n_checks = 0;
   int n_errs = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: plain byte arithmetic over ref_mem.
   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
      int nbytes, sh, idx;
      logic [31:0] ea, mask, word, val;
      nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      ea = addr - (addr % nbytes);
      e = '0;
      e.err = (size == 2'd3) || (addr < Base) || (addr >= Base + 32'd4096);
`ifdef LSU_ALIGN_CHECK_EN
      e.err = e.err || ((addr % nbytes) != 0);
`endif
      if (e.err) begin
         e.lat = 4'd1;
      end else begin
         idx  = int'((ea - Base) / 4);
         sh   = 8 * int'(ea % 4);
         mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
         e.aw = ea & ~32'h3;
         word = ref_mem[idx];
         if (we) begin
            e.wr    = 1'b1;
            e.wdata = (word & ~(mask << sh)) | ((wdata & mask) << sh);
            ref_mem[idx] = e.wdata;
            e.lat   = (nbytes == 4) ? 4'd2 : 4'd3;
         end else begin
            val = (word >> sh) & mask;
            if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
            e.rdata = val;
            e.lat   = 4'd2;
         end
      end
   endtask

   // Per-cycle compare against the armed expectation
   exp_t        m_e = '0;
   logic        m_active = 1'b0;
   logic        m_en = 1'b0;
   int          m_cnt = 0;
   int          last_lat = 0;
   logic        last_err = 1'b0;
   logic [31:0] last_rdata = '0;
   logic [31:0] last_wdata = '0;

   always @(negedge clk) begin
      if (m_en) begin
         if (m_active) begin
            m_cnt = m_cnt + 1;
            chk("req_ready low while busy", 32'(bus.req_ready), 32'd0);
            chk("MemWrite strobe", 32'(bus.MemWrite), 32'(m_e.wr && (m_cnt == m_e.lat - 1)));
            if (!m_e.err && m_cnt < m_e.lat) chk("RAM address A", bus.A, m_e.aw);
            if (bus.MemWrite) last_wdata = bus.WriteData;
            if (m_e.wr && m_cnt == m_e.lat - 1) chk("WriteData", bus.WriteData, m_e.wdata);
            chk("resp_valid timing", 32'(bus.resp_valid), 32'(m_cnt == m_e.lat));
            if (bus.resp_valid) begin
               last_lat   = m_cnt;
               last_err   = bus.resp_err;
               last_rdata = bus.resp_rdata;
            end
            if (m_cnt >= m_e.lat) begin
               chk("resp_err", 32'(bus.resp_err), 32'(m_e.err));
               chk("resp_rdata", bus.resp_rdata, m_e.rdata);
               m_active = 1'b0;
            end
         end else begin
            chk("idle req_ready", 32'(bus.req_ready), 32'd1);
            chk("idle resp_valid", 32'(bus.resp_valid), 32'd0);
            chk("idle MemWrite", 32'(bus.MemWrite), 32'd0);
         end
      end
   end

   task automatic poke(input int idx, input logic [31:0] val);
      poke_idx = 10'(idx);
      poke_val = val;
      poke_en  = 1'b1;
      @(posedge clk);
      #1 poke_en = 1'b0;
      ref_mem[idx] = val;
   endtask

   // Called in the low clock phase; returns in the low phase of the response cycle.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
      exp_t e;
      int   n;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         #1 n++;
      end
      chk("req_ready before request", 32'(bus.req_ready), 32'd1);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      model(we, size, uns, addr, wdata, e);
      @(posedge clk);
      #1;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'($urandom);
      bus.req_size     = 2'($urandom);
      bus.req_addr     = $urandom;
      bus.req_wdata    = $urandom;
      m_e      = e;
      m_cnt    = 0;
      m_active = 1'b1;
      n = 0;
      while (m_active && n < 10) begin
         @(negedge clk);
         #1 n++;
      end
      if (m_active) begin
         chk("response timeout", 32'(m_active), 32'd0);
         m_active = 1'b0;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] edges [9];
      logic [31:0] a;
      logic [1:0]  sz;
      edges = '{32'h0000_0FFC, 32'h0000_0FFF, 32'h0000_1FF8, 32'h0000_1FFC, 32'h0000_1FFE,
                32'h0000_1FFF, 32'h0000_2000, 32'h0000_2002, 32'hFFFF_FFFC};
      for (int i = 0; i < Words; i++) ref_mem[i] = '0;
      bus.req_valid = 1'b0;
      bus.req_we = 1'b0;
      bus.req_size = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr = '0;
      bus.req_wdata = '0;

      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("reset req_ready", 32'(bus.req_ready), 32'd1);
      chk("reset MemWrite", 32'(bus.MemWrite), 32'd0);
      chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("reset resp_err", 32'(bus.resp_err), 32'd0);
      chk("reset resp_rdata", bus.resp_rdata, 32'd0);
      chk("reset A", bus.A, 32'h0000_1000);
      chk("reset WriteData", bus.WriteData, 32'd0);
      m_en = 1'b1;

      for (int i = 0; i < 16; i++) poke(i, $urandom);
      poke(1022, $urandom);
      poke(1023, $urandom);

      // Word store then word load
      do_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'h0000_13FF);
      chk("word store WriteData", last_wdata, 32'h0000_13FF);
      chk("word store latency", 32'(last_lat), 32'd2);
      do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
      chk("word load data", last_rdata, 32'h0000_13FF);
      chk("word load latency", 32'(last_lat), 32'd2);

      // Byte store read-modify-write
      poke(1, 32'h0000_0100);
      do_req(1'b1, 2'b00, 1'b0, 32'h1006, 32'hFFFF_FFAB);
      chk("byte store WriteData", last_wdata, 32'h00AB_0100);
      chk("byte store latency", 32'(last_lat), 32'd3);

      // Extension of sub-word loads
      poke(1, 32'h80FF_7F80);
      do_req(1'b0, 2'b00, 1'b0, 32'h1004, 32'h0);
      chk("signed byte load", last_rdata, 32'hFFFF_FF80);
      do_req(1'b0, 2'b00, 1'b1, 32'h1004, 32'h0);
      chk("unsigned byte load", last_rdata, 32'h0000_0080);
      do_req(1'b0, 2'b01, 1'b0, 32'h1006, 32'h0);
      chk("signed half load", last_rdata, 32'hFFFF_80FF);

      // Error responses
      do_req(1'b0, 2'b10, 1'b0, 32'h1002, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
      chk("misaligned word err", 32'(last_err), 32'd1);
      chk("misaligned word latency", 32'(last_lat), 32'd1);
`else
      chk("masked word load data", last_rdata, 32'h0000_13FF);
      chk("masked word load latency", 32'(last_lat), 32'd2);
`endif
      do_req(1'b1, 2'b10, 1'b0, 32'h0FFC, 32'h1234_5678);
      chk("out-of-range store err", 32'(last_err), 32'd1);
      chk("out-of-range store latency", 32'(last_lat), 32'd1);
      do_req(1'b0, 2'b11, 1'b0, 32'h1000, 32'h0);
      chk("illegal size err", 32'(last_err), 32'd1);
      chk("illegal size latency", 32'(last_lat), 32'd1);

      // Reset during the WR cycle of a byte store
      poke(1, 32'h0000_0100);
      @(negedge clk);
      #1 m_en = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_we = 1'b1;
      bus.req_size = 2'b00;
      bus.req_addr = 32'h1006;
      bus.req_wdata = 32'h0000_00AB;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      #1 chk("abort RD address", bus.A, 32'h0000_1004);
      @(negedge clk);
      #1 chk("abort WR strobe before reset", 32'(bus.MemWrite), 32'd1);
      rst = 1'b0;
      #1;
      chk("abort MemWrite in reset cycle", 32'(bus.MemWrite), 32'd0);
      chk("abort resp_valid in reset cycle", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("abort no resp_valid", 32'(bus.resp_valid), 32'd0);
         chk("abort req_ready", 32'(bus.req_ready), 32'd1);
         chk("abort no MemWrite", 32'(bus.MemWrite), 32'd0);
         @(negedge clk);
         #1;
      end
      m_en = 1'b1;
      do_req(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0);
      chk("abort word unmodified", last_rdata, 32'h0000_0100);

      // Randomized traffic
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 7) == 0) a = edges[$urandom_range(0, 8)];
         else a = Base + 32'($urandom_range(0, 63));
         sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         do_req(1'($urandom), sz, 1'($urandom), a, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule
